fetch_unit: RTL and testbench

//  Instruction-fetch stage in front of the word-addressed memory block. Keeps a word PC, issues

---
 rtl/arv_pkg.sv | 29 ++
 rtl/fetch_unit_fifo.sv | 76 +++++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/arv_pkg.sv
// Shared types and sizing helpers for the instruction-fetch slice.
package arv_pkg;

   localparam int ARV_WIDTH = 32;
   localparam int ARV_DEPTH = 1024;

   // Address width for a word-addressed memory of the given depth (at least 1 bit).
   function automatic int arv_aw(input int depth);
      if (depth <= 1) begin
         return 1;
      end else begin
         return $clog2(depth);
      end
   endfunction

   localparam int ARV_AW = arv_aw(ARV_DEPTH);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ARV_AW-1:0]    pc;
      logic [ARV_WIDTH-1:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO of fetched {pc, data} entries. Pointers carry a wrap bit so
// full and empty are told apart without a separate counter. A flush empties the
// buffer and wins over a push in the same cycle; a pop in that cycle has
// already been taken by the consumer.
module fetch_fifo
   import arv_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        push_i,
   input  fetch_entry_t                push_data_i,
   input  logic                        pop_i,
   input  logic                        flush_i,
   output fetch_entry_t                head_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [$clog2(FIFO_DEPTH):0] count_o
);

   localparam int PW = $clog2(FIFO_DEPTH);

   fetch_entry_t  mem_q [FIFO_DEPTH];
   logic [PW:0]   wr_q, wr_d;
   logic [PW:0]   rd_q, rd_d;
   logic          do_push_s;
   logic          do_pop_s;

   assign empty_o   = (wr_q == rd_q);
   assign full_o    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign count_o   = wr_q - rd_q;
   assign head_o    = mem_q[rd_q[PW-1:0]];
   assign do_pop_s  = pop_i && !empty_o;
   assign do_push_s = push_i && !flush_i && (!full_o || do_pop_s);

   // Next pointer values: flush resets both, otherwise advance on push/pop.
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (do_push_s) begin
            wr_d = wr_q + {{PW{1'b0}}, 1'b1};
         end else begin
            wr_d = wr_q;
         end
         if (do_pop_s) begin
            rd_d = rd_q + {{PW{1'b0}}, 1'b1};
         end else begin
            rd_d = rd_q;
         end
      end
   end

   // Pointer registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Entry storage; contents are only observed behind a valid head.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_q[wr_q[PW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: word PC, single-word reads with one-cycle latency,
// PC-tagged responses buffered toward decode, redirect flush and halt.
// A read is issued only when its response is guaranteed a FIFO slot, counting
// the response and the decode pop happening in the current cycle, which keeps
// one word per cycle flowing with a two-entry buffer.
module fetch_unit
   import arv_pkg::*;
#(
   parameter int WIDTH      = ARV_WIDTH,
   parameter int DEPTH      = ARV_DEPTH,
   parameter int RESET_PC   = 0,
   parameter int FIFO_DEPTH = 2,
   localparam int AW        = arv_aw(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             halt_i,
   input  logic             redirect_i,
   input  logic [AW-1:0]    redirect_pos_i,
   output logic             mem_read_en_o,
   output logic [AW-1:0]    mem_read_pos_o,
   input  logic [WIDTH-1:0] mem_read_data_i,
   input  logic             mem_read_valid_i,
   output logic             instr_valid_o,
   input  logic             instr_ready_i,
   output logic [WIDTH-1:0] instr_data_o,
   output logic [AW-1:0]    instr_pc_o
);

   localparam int            CW           = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0]   FIFO_DEPTH_L = (CW+1)'(FIFO_DEPTH);
   localparam logic [AW-1:0] LAST_PC      = AW'(DEPTH - 1);
   localparam logic [AW-1:0] RESET_PC_L   = AW'(RESET_PC);

   fetch_state_e  state_q;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] tag_q;
   logic          pending_q;

   fetch_entry_t  push_entry_s;
   fetch_entry_t  head_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic [CW-1:0] fifo_count_s;

   logic          redirect_s;
   logic          resp_s;
   logic          stall_s;
   logic          pop_s;
   logic [CW:0]   occ_s;
   logic          issue_s;

   assign redirect_s   = redirect_i && (state_q != BOOT);
   assign resp_s       = pending_q && mem_read_valid_i;
   assign stall_s      = pending_q && !mem_read_valid_i;
   assign pop_s        = !fifo_empty_s && instr_ready_i;
   assign occ_s        = {1'b0, fifo_count_s} + {{CW{1'b0}}, resp_s} - {{CW{1'b0}}, pop_s};
   assign issue_s      = (state_q == RUN) && !halt_i && !redirect_s && !stall_s &&
                         !(fifo_full_s && !pop_s) && (occ_s < FIFO_DEPTH_L);
   assign push_entry_s = '{pc: tag_q, data: mem_read_data_i};

   fetch_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (resp_s),
      .push_data_i (push_entry_s),
      .pop_i       (pop_s),
      .flush_i     (redirect_s),
      .head_o      (head_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s),
      .count_o     (fifo_count_s)
   );

   // Sequential PC successor, wrapping at the top of memory.
   always_comb begin
      if (pc_q == LAST_PC) begin
         pc_d = '0;
      end else begin
         pc_d = pc_q + {{(AW-1){1'b0}}, 1'b1};
      end
   end

   // Memory request and decode-side outputs; idle values are zero.
   always_comb begin
      mem_read_en_o = issue_s;
      instr_valid_o = !fifo_empty_s;
      if (issue_s) begin
         mem_read_pos_o = pc_q;
      end else begin
         mem_read_pos_o = '0;
      end
      if (fifo_empty_s) begin
         instr_data_o = '0;
         instr_pc_o   = '0;
      end else begin
         instr_data_o = head_s.data;
         instr_pc_o   = head_s.pc;
      end
   end

   // Fetch FSM with PC, in-flight tracking and redirect handling.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC_L;
         pending_q <= 1'b0;
         tag_q     <= '0;
      end else begin
         case (state_q)
            BOOT:    state_q <= RUN;
            RUN:     state_q <= halt_i ? HALT : RUN;
            HALT:    state_q <= halt_i ? HALT : RUN;
            default: state_q <= BOOT;
         endcase
         if (redirect_s) begin
            pc_q      <= redirect_pos_i;
            pending_q <= 1'b0;
         end else if (issue_s) begin
            pc_q      <= pc_d;
            pending_q <= 1'b1;
            tag_q     <= pc_q;
         end else if (resp_s) begin
            pending_q <= 1'b0;
         end else begin
            pending_q <= pending_q;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural memory (word[i] = 0xA000_0000 + i), an
// expected-PC scoreboard refilled on reset/redirect, and a monitor that pops and
// compares on every decode handshake.
module tb_fetch_unit;

   localparam int AW    = 10;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic halt = 1'b0;
   logic redir = 1'b0;
   logic [AW-1:0] redir_pos = '0;
   logic ready = 1'b1;
   logic stall = 1'b0;

   logic          a_rd_en, a_valid;
   logic [AW-1:0] a_rd_pos, a_pc;
   logic [31:0]   a_data, a_mem_data = 32'd0;
   logic          a_mem_valid_q = 1'b0;

   logic          b_rd_en, b_valid;
   logic [AW-1:0] b_rd_pos, b_pc;
   logic [31:0]   b_data, b_mem_data = 32'd0;
   logic          b_mem_valid_q = 1'b0;

   int checks = 0;
   int passes = 0;
   int reads_cnt = 0;
   int exp_q [$];

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(0)) dut_a (
      .clk_i(clk), .rst_i(rst), .halt_i(halt), .redirect_i(redir), .redirect_pos_i(redir_pos),
      .mem_read_en_o(a_rd_en), .mem_read_pos_o(a_rd_pos), .mem_read_data_i(a_mem_data),
      .mem_read_valid_i(a_mem_valid_q && !stall), .instr_valid_o(a_valid),
      .instr_ready_i(ready), .instr_data_o(a_data), .instr_pc_o(a_pc));

   fetch_unit #(.RESET_PC(DEPTH-2)) dut_b (
      .clk_i(clk), .rst_i(rst), .halt_i(1'b0), .redirect_i(1'b0), .redirect_pos_i(10'd0),
      .mem_read_en_o(b_rd_en), .mem_read_pos_o(b_rd_pos), .mem_read_data_i(b_mem_data),
      .mem_read_valid_i(b_mem_valid_q), .instr_valid_o(b_valid),
      .instr_ready_i(1'b1), .instr_data_o(b_data), .instr_pc_o(b_pc));

   // Memory models: one-cycle read latency, valid stays high after the first read.
   always @(posedge clk) begin
      if (a_rd_en) begin
         a_mem_data    <= 32'hA000_0000 + {22'd0, a_rd_pos};
         a_mem_valid_q <= 1'b1;
      end
      if (b_rd_en) begin
         b_mem_data    <= 32'hA000_0000 + {22'd0, b_rd_pos};
         b_mem_valid_q <= 1'b1;
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end else begin
         passes++;
      end
   endtask

   // Expected stream after reset/redirect: consecutive word PCs modulo DEPTH.
   task automatic rebuild(input int start);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back((start + i) % DEPTH);
   endtask

   // Read-request counter since the last reset.
   always @(negedge clk) begin
      if (rst) reads_cnt = 0;
      else if (a_rd_en) reads_cnt = reads_cnt + 1;
   end

   // Monitor: stability, ordered delivery, halt behaviour.
   logic          p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0, p_halt = 1'b0;
   logic [AW-1:0] p_pc = '0;
   logic [31:0]   p_data = 32'd0;
   always @(negedge clk) begin
      int e;
      if (rst) begin
         rebuild(0);
         p_valid = 1'b0;
      end else begin
         if (p_valid && !p_ready && !p_redir) begin
            check("hold_valid", {63'd0, a_valid}, 64'd1);
            check("hold_pc", {54'd0, a_pc}, {54'd0, p_pc});
            check("hold_data", {32'd0, a_data}, {32'd0, p_data});
         end
         if (a_valid && ready) begin
            e = exp_q.pop_front();
            check("stream_pc", {54'd0, a_pc}, 64'(e));
            check("stream_data", {32'd0, a_data}, 64'(32'hA000_0000 + e));
            exp_q.push_back((exp_q[$] + 1) % DEPTH);
         end
         if (redir) rebuild(int'(redir_pos));
         if (p_halt && halt) check("halt_no_issue", {63'd0, a_rd_en}, 64'd0);
         p_valid = a_valid;
      end
      p_ready = ready; p_redir = redir; p_halt = halt; p_pc = a_pc; p_data = a_data;
   end

   // Wrap-around instance: first four words after the initial reset.
   initial begin
      int got;
      int exp_b [4];
      exp_b = '{1022, 1023, 0, 1};
      got = 0;
      wait (rst == 1'b0);
      for (int c = 0; c < 40 && got < 4; c++) begin
         @(negedge clk);
         if (b_valid) begin
            check("wrap_pc", {54'd0, b_pc}, 64'(exp_b[got]));
            check("wrap_data", {32'd0, b_data}, 64'(32'hA000_0000 + exp_b[got]));
            got++;
         end
      end
      check("wrap_count", 64'(got), 64'd4);
   end

   // Time bound.
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic wait_valid(input string nm);
      int n;
      n = 0;
      while (!a_valid && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check(nm, {63'd0, a_valid}, 64'd1);
   endtask

   initial begin
      // 1: reset state, boot cycle, latency and back-to-back delivery.
      ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("boot_rd_en", {63'd0, a_rd_en}, 64'd0);
      check("rst_pos", {54'd0, a_rd_pos}, 64'd0);
      check("rst_valid", {63'd0, a_valid}, 64'd0);
      check("rst_data", {32'd0, a_data}, 64'd0);
      check("rst_pc", {54'd0, a_pc}, 64'd0);
      @(negedge clk);
      check("first_rd_en", {63'd0, a_rd_en}, 64'd1);
      check("first_rd_pos", {54'd0, a_rd_pos}, 64'd0);
      @(negedge clk);
      check("lat_n1_valid", {63'd0, a_valid}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_bubble", {63'd0, a_valid}, 64'd1);
      end

      // 2: back-pressure limits outstanding reads to the buffer depth.
      ready = 1'b0;
      do_reset();
      wait_valid("bp_first_valid");
      repeat (10) @(posedge clk);
      #1;
      check("bp_reads", 64'(reads_cnt), 64'd2);
      ready = 1'b1;
      repeat (10) @(posedge clk);

      // 3: redirect with full FIFO, head popped in the same cycle.
      #1 ready = 1'b0;
      @(posedge clk); #1;
      ready = 1'b1; redir = 1'b1; redir_pos = 10'h100;
      @(posedge clk); #1 redir = 1'b0;
      wait_valid("redir_valid");
      check("redir_pc", {54'd0, a_pc}, 64'h100);
      repeat (8) @(posedge clk);

      // 5: halt mid-stream, drain, resume.
      #1 halt = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("halt_drained", {63'd0, a_valid}, 64'd0);
      halt = 1'b0;
      repeat (8) @(posedge clk);

      // 6: reset with a read pending and the FIFO non-empty.
      #1 ready = 1'b0;
      do_reset();
      wait_valid("pre_rst_valid");
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst6_valid", {63'd0, a_valid}, 64'd0);
      check("rst6_rd_en", {63'd0, a_rd_en}, 64'd0);
      check("rst6_pos", {54'd0, a_rd_pos}, 64'd0);
      check("rst6_data", {32'd0, a_data}, 64'd0);
      check("rst6_pc", {54'd0, a_pc}, 64'd0);
      @(posedge clk); #1 ready = 1'b1;
      wait_valid("rst6_restart");
      check("rst6_restart_pc", {54'd0, a_pc}, 64'd0);

      // Randomised traffic: back-pressure, memory stalls, halts and redirects.
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         ready = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) halt = !halt;
         redir = ($urandom_range(0, 31) == 0);
         redir_pos = AW'($urandom_range(0, DEPTH - 1));
      end
      @(posedge clk); #1;
      ready = 1'b1; stall = 1'b0; halt = 1'b0; redir = 1'b0;
      repeat (10) @(posedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
